// File: rtl/lenet_frame_downsampler_if.sv
// Pixel-stream input and LeNet input-memory write port of lenet_frame_downsampler.
// master = pixel source / memory side, slave = the downsampler.
interface lenet_frame_downsampler_if #(
    parameter int ADDR_W = 10
);
    logic              arm;
    logic              pix_valid;
    logic              pix_sof;
    logic [7:0]        pix_data;
    logic [ADDR_W-1:0] lenet_addr;
    logic [7:0]        lenet_dout;
    logic              lenet_we;
    logic              data_ready;
    logic              busy;

    modport master (
        output arm, pix_valid, pix_sof, pix_data,
        input  lenet_addr, lenet_dout, lenet_we, data_ready, busy
    );

    modport slave (
        input  arm, pix_valid, pix_sof, pix_data,
        output lenet_addr, lenet_dout, lenet_we, data_ready, busy
    );
endinterface

// File: rtl/lenet_frame_downsampler.sv
// Box-sums a centred LENET_SIZE x LENET_SIZE grid of WIN_W x WIN_H windows from a raster
// stream and writes one byte per window. Optional macro: LENET_DS_AUTO_THRESHOLD_EN.
module lenet_frame_downsampler #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int WIN_W      = 8,
    parameter int WIN_H      = 8,
    parameter int LENET_SIZE = 28,
    parameter int PIX_W      = 4,
    parameter int MODE       = 0,
    parameter int THRESHOLD  = 384
) (
    input  logic                     clk25,
    input  logic                     rst_n,
    lenet_frame_downsampler_if.slave bus
);
    localparam int ACC_W  = PIX_W + $clog2(WIN_W * WIN_H);
    localparam int ADDR_W = $clog2(LENET_SIZE * LENET_SIZE);
    localparam int X_W    = $clog2(SCREEN_W);
    localparam int Y_W    = $clog2(SCREEN_H);
    localparam int WX_W   = $clog2(WIN_W);
    localparam int WY_W   = $clog2(WIN_H);
    localparam int GRID_W = $clog2(LENET_SIZE);
    localparam int ROI_W  = LENET_SIZE * WIN_W;
    localparam int ROI_H  = LENET_SIZE * WIN_H;
    localparam int X_OFF  = (SCREEN_W - ROI_W) / 2;
    localparam int Y_OFF  = (SCREEN_H - ROI_H) / 2;
    localparam int AVG_SH = $clog2(WIN_W * WIN_H);
    localparam logic [ACC_W-1:0] THR_C = ACC_W'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;

    state_e            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d, cur_x, rx;
    logic [Y_W-1:0]    y_q, y_d, cur_y, ry;
    logic [GRID_W-1:0] col, row;
    logic [WX_W-1:0]   pix_in_win;
    logic [WY_W-1:0]   line_in_band;
    logic              in_roi, proc, frame_start, first_px, emit, final_win;
    logic [ACC_W-1:0]  acc_q [LENET_SIZE];
    logic [ACC_W-1:0]  pix, sum, thr_active;
    logic [PIX_W-1:0]  mean;
    logic [7:0]        res_d, dout_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              we_q, last_q;
    logic              unused_pix_bits;

    assign unused_pix_bits = ^bus.pix_data[7:PIX_W];

    // sof overrides the running position for the pixel it accompanies.
    always_comb begin
        cur_x = bus.pix_sof ? '0 : x_q;
        cur_y = bus.pix_sof ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (bus.pix_valid) begin
            if (cur_x == X_W'(SCREEN_W - 1)) begin
                x_d = '0;
                y_d = (cur_y == Y_W'(SCREEN_H - 1)) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    always_comb begin
        in_roi = ({1'b0, cur_x} >= (X_W+1)'(X_OFF)) && ({1'b0, cur_x} < (X_W+1)'(X_OFF + ROI_W)) &&
                 ({1'b0, cur_y} >= (Y_W+1)'(Y_OFF)) && ({1'b0, cur_y} < (Y_W+1)'(Y_OFF + ROI_H));
        rx           = cur_x - X_W'(X_OFF);
        ry           = cur_y - Y_W'(Y_OFF);
        col          = GRID_W'(rx >> WX_W);
        row          = GRID_W'(ry >> WY_W);
        pix_in_win   = rx[WX_W-1:0];
        line_in_band = ry[WY_W-1:0];
    end

    // A frame restart is accepted in CAPTURE until the final write has been issued.
    always_comb begin
        frame_start = bus.pix_valid && bus.pix_sof &&
                      ((state_q == ARMED) || ((state_q == CAPTURE) && !last_q));
        proc        = frame_start || (bus.pix_valid && (state_q == CAPTURE) && !last_q);
        first_px    = (line_in_band == '0) && (pix_in_win == '0);
        emit        = proc && in_roi && (line_in_band == WY_W'(WIN_H - 1)) &&
                      (pix_in_win == WX_W'(WIN_W - 1));
        final_win   = emit && (row == GRID_W'(LENET_SIZE - 1)) && (col == GRID_W'(LENET_SIZE - 1));
        pix         = ACC_W'(bus.pix_data[PIX_W-1:0]);
        sum         = (first_px ? '0 : acc_q[col]) + pix;
        mean        = PIX_W'(sum >> AVG_SH);
        addr_d      = ADDR_W'(row) * ADDR_W'(LENET_SIZE) + ADDR_W'(col);
        if (MODE == 0) begin
            res_d = (sum >= thr_active) ? 8'hFF : 8'h00;
        end else begin
            res_d = 8'(mean) << (8 - PIX_W);
        end
    end

`ifdef LENET_DS_AUTO_THRESHOLD_EN
    localparam int FS_W = ACC_W + 2 * $clog2(LENET_SIZE) + 1;

    logic [FS_W-1:0]  fsum_q;
    logic [ACC_W-1:0] thr_q;
    logic             thr_valid_q;

    // Only a frame that reached its final write publishes a new threshold.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            fsum_q      <= '0;
            thr_q       <= '0;
            thr_valid_q <= 1'b0;
        end else begin
            if (frame_start) begin
                fsum_q <= in_roi ? FS_W'(pix) : '0;
            end else if (proc && in_roi) begin
                fsum_q <= fsum_q + FS_W'(pix);
            end
            if ((state_q == CAPTURE) && last_q) begin
                thr_q       <= ACC_W'(fsum_q / FS_W'(LENET_SIZE * LENET_SIZE));
                thr_valid_q <= 1'b1;
            end
        end
    end

    assign thr_active = thr_valid_q ? thr_q : THR_C;
`else
    assign thr_active = THR_C;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // NOTE: the accumulator bank is explicitly reset; it is small enough to be flops, and a
    // cleared bank keeps a reset mid-frame from leaking partial sums.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LENET_SIZE; i++) acc_q[i] <= '0;
        end else if (proc && in_roi) begin
            acc_q[col] <= sum;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            last_q <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            we_q   <= emit;
            last_q <= final_win;
            if (emit) begin
                addr_q <= addr_d;
                dout_q <= res_d;
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next state defaults to the current one so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.arm) state_d = ARMED;
            ARMED: begin
                if (bus.pix_valid && bus.pix_sof) state_d = CAPTURE;
                else if (!bus.arm)                state_d = IDLE;
            end
            CAPTURE: if (last_q) state_d = DONE;
            DONE:    state_d = bus.arm ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == ARMED) || (state_q == CAPTURE);
        bus.data_ready = (state_q == DONE);
        bus.lenet_we   = we_q;
        bus.lenet_addr = addr_q;
        bus.lenet_dout = dout_q;
    end
endmodule

// File: tb/tb_lenet_frame_downsampler.sv
// Scoreboard bench: a MODE 0 and a MODE 1 instance share one scaled-down pixel stream.
module tb_lenet_frame_downsampler;
    localparam int SW  = 48;
    localparam int SH  = 40;
    localparam int WW  = 8;
    localparam int WH  = 8;
    localparam int LS  = 4;
    localparam int NW  = LS * LS;
    localparam int XO  = (SW - LS * WW) / 2;
    localparam int YO  = (SH - LS * WH) / 2;
    localparam int AW  = $clog2(NW);
    localparam int THR = 384;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0, pix_valid = 1'b0, pix_sof = 1'b0;
    logic [7:0] pix_data = 8'h00;

    always #20 clk25 = ~clk25;

    lenet_frame_downsampler_if #(.ADDR_W(AW)) bus0 ();
    lenet_frame_downsampler_if #(.ADDR_W(AW)) bus1 ();

    assign bus0.arm = arm;  assign bus0.pix_valid = pix_valid;
    assign bus0.pix_sof = pix_sof;  assign bus0.pix_data = pix_data;
    assign bus1.arm = arm;  assign bus1.pix_valid = pix_valid;
    assign bus1.pix_sof = pix_sof;  assign bus1.pix_data = pix_data;

    lenet_frame_downsampler #(.SCREEN_W(SW), .SCREEN_H(SH), .WIN_W(WW), .WIN_H(WH),
        .LENET_SIZE(LS), .PIX_W(4), .MODE(0), .THRESHOLD(THR))
        dut0 (.clk25(clk25), .rst_n(rst_n), .bus(bus0));
    lenet_frame_downsampler #(.SCREEN_W(SW), .SCREEN_H(SH), .WIN_W(WW), .WIN_H(WH),
        .LENET_SIZE(LS), .PIX_W(4), .MODE(1), .THRESHOLD(THR))
        dut1 (.clk25(clk25), .rst_n(rst_n), .bus(bus1));

    int tests = 0, fails = 0;
    int wr0 = 0, wr1 = 0, dr0 = 0, dr1 = 0;
    logic [AW+7:0] q0[$], q1[$];
    logic [AW+7:0] e0, e1;
    logic          prev_we0 = 1'b0;
    logic [AW-1:0] prev_addr0 = '0;

    // Pattern and reference model state
    int pat_val = 0, pat_row = 0, pat_col = 0;
    bit pat_single = 1'b0;
    int exp0[NW], exp1[NW];
    int fmean = 0, thr_m = 0;
    bit thr_valid_m = 1'b0;

    always @(negedge clk25) begin
        if (bus0.lenet_we === 1'b1) begin
            wr0++;
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL wr0_unexpected: got addr %0d data %h, required no write",
                         bus0.lenet_addr, bus0.lenet_dout);
            end else begin
                e0 = q0.pop_front();
                if ({bus0.lenet_addr, bus0.lenet_dout} !== e0) begin
                    fails++;
                    $display("FAIL wr0_data: got addr %0d data %h, required addr %0d data %h",
                             bus0.lenet_addr, bus0.lenet_dout, e0[AW+7:8], e0[7:0]);
                end
            end
        end
        if (bus1.lenet_we === 1'b1) begin
            wr1++;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL wr1_unexpected: got addr %0d data %h, required no write",
                         bus1.lenet_addr, bus1.lenet_dout);
            end else begin
                e1 = q1.pop_front();
                if ({bus1.lenet_addr, bus1.lenet_dout} !== e1) begin
                    fails++;
                    $display("FAIL wr1_data: got addr %0d data %h, required addr %0d data %h",
                             bus1.lenet_addr, bus1.lenet_dout, e1[AW+7:8], e1[7:0]);
                end
            end
        end
        if (bus0.data_ready === 1'b1) begin
            dr0++;
            tests++;
            if (!(prev_we0 && (prev_addr0 == AW'(NW - 1)))) begin
                fails++;
                $display("FAIL dr0_timing: got prev_we %0b prev_addr %0d, required 1 and %0d",
                         prev_we0, prev_addr0, NW - 1);
            end
        end
        if (bus1.data_ready === 1'b1) dr1++;
        prev_we0   = (bus0.lenet_we === 1'b1);
        prev_addr0 = bus0.lenet_addr;
    end

    function automatic int pix_val(input int x, input int y);
        if (pat_single)
            return (x >= XO + pat_col * WW && x < XO + (pat_col + 1) * WW &&
                    y >= YO + pat_row * WH && y < YO + (pat_row + 1) * WH) ? pat_val : 0;
        return pat_val;
    endfunction

    task automatic build_expect();
        int s, fsum, thr_act;
        thr_act = thr_valid_m ? thr_m : THR;
        fsum = 0;
        for (int r = 0; r < LS; r++) begin
            for (int c = 0; c < LS; c++) begin
                s = 0;
                for (int dy = 0; dy < WH; dy++)
                    for (int dx = 0; dx < WW; dx++)
                        s += pix_val(XO + c * WW + dx, YO + r * WH + dy);
                exp0[r * LS + c] = (s >= thr_act) ? 255 : 0;
                exp1[r * LS + c] = (s / (WW * WH)) * 16;
                fsum += s;
            end
        end
        fmean = fsum / NW;
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_pixel(input int x, input int y, input bit sof);
        logic [31:0] r;
        if ($urandom_range(7) == 0) begin
            r = $urandom;
            pix_valid = 1'b0;
            pix_sof   = r[8];
            pix_data  = r[7:0];
            tick();
        end
        r = $urandom;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = {r[3:0], 4'(pix_val(x, y))};
        tick();
    endtask

    // Drives lines 0..stop_line-1 of a frame; expectations are queued at each trigger pixel.
    task automatic send_frame(input bit exp_cap, input int stop_line, input int drop_line);
        int idx;
        build_expect();
        for (int y = 0; y < stop_line; y++) begin
            for (int x = 0; x < SW; x++) begin
                if (y == drop_line && x == 0) arm = 1'b0;
                if (exp_cap && y >= YO && y < YO + LS * WH && x >= XO && x < XO + LS * WW &&
                    (y - YO) % WH == WH - 1 && (x - XO) % WW == WW - 1) begin
                    idx = ((y - YO) / WH) * LS + (x - XO) / WW;
                    q0.push_back({AW'(idx), 8'(exp0[idx])});
                    q1.push_back({AW'(idx), 8'(exp1[idx])});
                end
                send_pixel(x, y, (x == 0) && (y == 0));
            end
        end
`ifdef LENET_DS_AUTO_THRESHOLD_EN
        if (exp_cap && stop_line == SH) begin
            thr_m       = fmean;
            thr_valid_m = 1'b1;
        end
`endif
        idle(3);
    endtask

    task automatic frame_checks(input string name, input int w0, input int d0,
                                input int exp_w, input int exp_d);
        tests++;
        if (wr0 - w0 !== exp_w || wr1 - (w0 + (wr1 - wr0)) !== exp_w) begin
            fails++;
            $display("FAIL %s_writes: got %0d/%0d, required %0d", name, wr0 - w0,
                     wr1 - (w0 + (wr1 - wr0)), exp_w);
        end
        tests++;
        if (dr0 - d0 !== exp_d || dr1 !== dr0) begin
            fails++;
            $display("FAIL %s_ready: got %0d (mode1 total %0d vs %0d), required %0d",
                     name, dr0 - d0, dr1, dr0, exp_d);
        end
        tests++;
        if (q0.size() + q1.size() !== 0) begin
            fails++;
            $display("FAIL %s_pending: got %0d queued, required 0", name, q0.size() + q1.size());
        end
    endtask

    task automatic test_reset();
        logic [AW+10:0] o;
        rst_n = 1'b0;
        idle(2);
        o = {bus0.lenet_we, bus0.data_ready, bus0.busy, bus0.lenet_addr, bus0.lenet_dout};
        tests++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", o);
        end
        rst_n = 1'b1;
        idle(2);
        tests++;
        if (bus0.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b, required 0", bus0.busy);
        end
        arm = 1'b1;
        idle(2);
        tests++;
        if (bus0.busy !== 1'b1) begin
            fails++;
            $display("FAIL armed_busy: got %b, required 1", bus0.busy);
        end
    endtask

    task automatic test_full_frame();
        int w0 = wr0, d0 = dr0;
        pat_single = 1'b0;
        pat_val = 15;
        send_frame(1'b1, SH, -1);
        frame_checks("full", w0, d0, NW, 1);
        tests++;
        if (bus0.busy !== 1'b1) begin
            fails++;
            $display("FAIL full_rearmed_busy: got %b, required 1", bus0.busy);
        end
    endtask

    task automatic test_uniform_levels();
        int vals[3] = '{5, 6, 9};
        int w0, d0;
        pat_single = 1'b0;
        foreach (vals[i]) begin
            w0 = wr0;
            d0 = dr0;
            pat_val = vals[i];
            send_frame(1'b1, SH, -1);
            frame_checks("uniform", w0, d0, NW, 1);
        end
    endtask

    task automatic test_single_window();
        int w0 = wr0, d0 = dr0;
        pat_single = 1'b1;
        pat_val = 15;
        pat_row = 2;
        pat_col = 1;
        send_frame(1'b1, SH, -1);
        frame_checks("single", w0, d0, NW, 1);
        pat_single = 1'b0;
    endtask

    task automatic test_abort();
        int w0 = wr0, d0 = dr0;
        pat_val = 6;
        send_frame(1'b1, 15, -1);
        frame_checks("abort_part", w0, d0, LS, 0);
        w0 = wr0;
        send_frame(1'b1, SH, -1);
        frame_checks("abort_restart", w0, d0, NW, 1);
    endtask

    task automatic test_arm_low();
        int w0 = wr0, d0 = dr0;
        arm = 1'b0;
        idle(2);
        tests++;
        if (bus0.busy !== 1'b0) begin
            fails++;
            $display("FAIL armlow_busy_before: got %b, required 0", bus0.busy);
        end
        pat_val = 15;
        send_frame(1'b0, SH, -1);
        frame_checks("armlow", w0, d0, 0, 0);
        tests++;
        if (bus0.busy !== 1'b0) begin
            fails++;
            $display("FAIL armlow_busy_after: got %b, required 0", bus0.busy);
        end
    endtask

    task automatic test_arm_drop();
        int w0 = wr0, d0 = dr0;
        arm = 1'b1;
        idle(2);
        pat_val = 9;
        send_frame(1'b1, SH, 20);
        frame_checks("armdrop", w0, d0, NW, 1);
        tests++;
        if (bus0.busy !== 1'b0) begin
            fails++;
            $display("FAIL armdrop_idle: got busy %b, required 0", bus0.busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w0 = wr0, d0 = dr0;
        logic [AW+10:0] o;
        arm = 1'b1;
        idle(2);
        pat_val = 15;
        send_frame(1'b1, 25, -1);
        tests++;
        if (bus0.busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_busy_before: got %b, required 1", bus0.busy);
        end
        #5 rst_n = 1'b0;
        #1 o = {bus0.lenet_we, bus0.data_ready, bus0.busy, bus0.lenet_addr, bus0.lenet_dout};
        tests++;
        if (o !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h, required 0", o);
        end
        thr_valid_m = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(1'b1, SH, -1);
        frame_checks("midreset", w0, d0, 2 * LS + NW, 1);
    endtask

    task automatic test_auto_threshold();
        int w0 = wr0, d0 = dr0;
        rst_n = 1'b0;
        thr_valid_m = 1'b0;
        idle(2);
        rst_n = 1'b1;
        arm = 1'b1;
        idle(2);
        pat_val = 3;
        send_frame(1'b1, SH, -1);
        send_frame(1'b1, SH, -1);
        frame_checks("auto", w0, d0, 2 * NW, 2);
    endtask

    initial begin
        tick();
        test_reset();
        test_full_frame();
        test_uniform_levels();
        test_single_window();
        test_abort();
        test_arm_low();
        test_arm_drop();
        test_reset_mid_frame();
        test_auto_threshold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
